// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer
//   Multi-channel Avalon-MM timer. NUM_CHANNELS independent COUNT_WIDTH-bit
//   up-counters, each with a compare register, a run mode (free-run,
//   auto-reload, one-shot), a match flag and an interrupt enable.
//
//   Optional feature macro: TIMER_PRESCALE_EN
//     Adds a per-channel PRESCALE_W-bit prescaler. Its reload value comes from
//     CONFIG[31:16]. Without the macro, a tick occurs every cycle and
//     CONFIG[31:16] reads as 0.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    [7:5] must be 0, [4:2] channel, [1:0] register
//   write      single-cycle write strobe
//   writedata  write data
//   read       read strobe
//   readdata   registered read data, 1-cycle latency, held between reads
//   irq        registered OR of (match_flag & irq_en) over all channels
//
// Register map per channel
//   0 CMD/STATUS  wr [2:0]: 1 start, 2 stop, 3 clear count, 4 clear flag
//                 rd [0] running, [1] match_flag, [3:2] mode, [4] irq_en
//   1 COUNT       a write loads the count only while the channel is stopped
//   2 COMPARE
//   3 CONFIG      [1:0] mode, [2] irq_en, [31:16] prescale reload
module avalon_multi_timer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } ch_state_e;

  logic [2:0] ch_sel;
  logic [1:0] reg_sel;
  logic       addr_ok;

  assign ch_sel  = address[4:2];
  assign reg_sel = address[1:0];
  assign addr_ok = (address[7:5] == 3'b000) && (32'(ch_sel) < NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0][31:0] status_word;
  logic [NUM_CHANNELS-1:0][31:0] count_word;
  logic [NUM_CHANNELS-1:0][31:0] compare_word;
  logic [NUM_CHANNELS-1:0][31:0] config_word;
  logic [NUM_CHANNELS-1:0]       irq_vec;
  logic [31:0]                   rd_next;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    ch_state_e              state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] compare_q, compare_d;
    logic                   match_q, match_d;
    logic [1:0]             mode_q, mode_d;
    logic                   irq_en_q, irq_en_d;
    logic                   sel;
    logic [2:0]             cmd;
    logic                   tick;

    assign sel = write && addr_ok && (ch_sel == 3'(c));
    assign cmd = (sel && (reg_sel == 2'd0)) ? writedata[2:0] : 3'd0;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] reload_q, reload_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    assign tick = (state_q == ST_RUNNING) && (presc_q == '0);
`else
    assign tick = (state_q == ST_RUNNING);
`endif

    always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      compare_d = compare_q;
      match_d   = match_q;
      mode_d    = mode_q;
      irq_en_d  = irq_en_q;
`ifdef TIMER_PRESCALE_EN
      reload_d  = reload_q;
      presc_d   = presc_q;
`endif

      // Clear is applied first so that a match in the same cycle wins.
      if (cmd == 3'd4) match_d = 1'b0;

      case (state_q)
        ST_STOPPED: begin
          if (cmd == 3'd1) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (cmd == 3'd2) state_d = ST_STOPPED;
          // Clear-count suppresses match evaluation; stop freezes the count
          // but still lets a coincident match set the flag.
          if ((cmd != 3'd3) && tick) begin
            if (count_q == compare_q) begin
              match_d = 1'b1;
              if (cmd != 3'd2) begin
                case (mode_q)
                  2'd1:    count_d = '0;
                  2'd2:    state_d = ST_STOPPED;
                  default: count_d = count_q + COUNT_WIDTH'(1);
                endcase
              end
            end else if (cmd != 3'd2) begin
              count_d = count_q + COUNT_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_STOPPED;
      endcase

      if (cmd == 3'd3) count_d = '0;

      if (sel && (reg_sel == 2'd1) && (state_q == ST_STOPPED))
        count_d = writedata[COUNT_WIDTH-1:0];
      if (sel && (reg_sel == 2'd2))
        compare_d = writedata[COUNT_WIDTH-1:0];
      if (sel && (reg_sel == 2'd3)) begin
        mode_d   = writedata[1:0];
        irq_en_d = writedata[2];
`ifdef TIMER_PRESCALE_EN
        reload_d = PRESCALE_W'(writedata[31:16]);
`endif
      end

`ifdef TIMER_PRESCALE_EN
      if ((cmd == 3'd3) || ((state_q == ST_STOPPED) && (cmd == 3'd1)))
        presc_d = reload_q;
      else if (state_q == ST_RUNNING)
        presc_d = (presc_q == '0) ? reload_q : presc_q - PRESCALE_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= ST_STOPPED;
        count_q   <= '0;
        compare_q <= '0;
        match_q   <= 1'b0;
        mode_q    <= '0;
        irq_en_q  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
        reload_q  <= '0;
        presc_q   <= '0;
`endif
      end else begin
        state_q   <= state_d;
        count_q   <= count_d;
        compare_q <= compare_d;
        match_q   <= match_d;
        mode_q    <= mode_d;
        irq_en_q  <= irq_en_d;
`ifdef TIMER_PRESCALE_EN
        reload_q  <= reload_d;
        presc_q   <= presc_d;
`endif
      end
    end

    assign status_word[c]  = {27'd0, irq_en_q, mode_q, match_q, (state_q == ST_RUNNING)};
    assign count_word[c]   = 32'(count_q);
    assign compare_word[c] = 32'(compare_q);
`ifdef TIMER_PRESCALE_EN
    assign config_word[c]  = {16'(reload_q), 13'd0, irq_en_q, mode_q};
`else
    assign config_word[c]  = {29'd0, irq_en_q, mode_q};
`endif
    assign irq_vec[c] = match_q & irq_en_q;
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (addr_ok && (ch_sel == 3'(c))) begin
        case (reg_sel)
          2'd0:    rd_next = status_word[c];
          2'd1:    rd_next = count_word[c];
          2'd2:    rd_next = compare_word[c];
          default: rd_next = config_word[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (read) readdata <= rd_next;
      irq <= |irq_vec;
    end
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
module tb_avalon_multi_timer;
  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned MASK = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        irq;

  avalon_multi_timer #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW), .PRESCALE_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: channel state as plain numbers, updated once per clock.
  bit          m_run[NCH];
  bit          m_flag[NCH];
  bit          m_ien[NCH];
  int unsigned m_cnt[NCH];
  int unsigned m_cmp[NCH];
  int unsigned m_mode[NCH];
  int unsigned m_rel[NCH];
  int unsigned m_psc[NCH];
  logic [31:0] m_rd;
  bit          m_irq;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_flag[i] = 0; m_ien[i] = 0; m_cnt[i] = 0;
      m_cmp[i] = 0; m_mode[i] = 0; m_rel[i] = 0; m_psc[i] = 0;
    end
    m_rd = '0; m_irq = 0;
  endtask

  function automatic logic [31:0] m_reg(int unsigned ch, int unsigned rg);
    case (rg)
      0: return {27'd0, m_ien[ch], 2'(m_mode[ch]), m_flag[ch], m_run[ch]};
      1: return 32'(m_cnt[ch]);
      2: return 32'(m_cmp[ch]);
      default: return (m_rel[ch] << 16) | (32'(m_ien[ch]) << 2) | m_mode[ch];
    endcase
  endfunction

  task automatic model_step(input bit w, input bit r, input logic [7:0] a, input logic [31:0] d);
    int unsigned ch = a[4:2];
    int unsigned rg = a[1:0];
    bit ok = (a[7:5] == 3'b000) && (ch < NCH);
    bit nirq = 0;
    if (r) m_rd = ok ? m_reg(ch, rg) : 32'd0;
    for (int i = 0; i < NCH; i++) if (m_flag[i] && m_ien[i]) nirq = 1;
    m_irq = nirq;
    for (int i = 0; i < NCH; i++) begin
      bit mine = w && ok && (ch == i);
      int unsigned cmd = (mine && rg == 0) ? d[2:0] : 0;
      bit was_run = m_run[i];
      bit tick;
`ifdef TIMER_PRESCALE_EN
      tick = was_run && (m_psc[i] == 0);
`else
      tick = was_run;
`endif
      if (cmd == 4) m_flag[i] = 0;
      if (cmd == 3) m_cnt[i] = 0;
      else if (tick) begin
        if (m_cnt[i] == m_cmp[i]) begin
          m_flag[i] = 1;
          if (cmd != 2) begin
            if (m_mode[i] == 1) m_cnt[i] = 0;
            else if (m_mode[i] == 2) m_run[i] = 0;
            else m_cnt[i] = (m_cnt[i] + 1) & MASK;
          end
        end else if (cmd != 2) m_cnt[i] = (m_cnt[i] + 1) & MASK;
      end
      if (cmd == 2) m_run[i] = 0;
      if (cmd == 1 && !was_run) m_run[i] = 1;
      if (cmd == 3 || (cmd == 1 && !was_run)) m_psc[i] = m_rel[i];
      else if (was_run) m_psc[i] = (m_psc[i] == 0) ? m_rel[i] : m_psc[i] - 1;
      if (mine && rg == 1 && !was_run) m_cnt[i] = d & MASK;
      if (mine && rg == 2) m_cmp[i] = d & MASK;
      if (mine && rg == 3) begin
        m_mode[i] = d[1:0];
        m_ien[i]  = d[2];
`ifdef TIMER_PRESCALE_EN
        m_rel[i]  = d[31:16];
`endif
      end
    end
  endtask

  function automatic logic [7:0] ra(int unsigned ch, int unsigned rg);
    return {3'b000, 3'(ch), 2'(rg)};
  endfunction

  // One bus cycle: drive on the falling edge, step the model on the rising edge.
  task automatic bus(input bit w, input bit r, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    write = w; read = r; address = a; writedata = d;
    @(posedge clk);
    model_step(w, r, a, d);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: readdata=%0h irq=%b, required 0/0", readdata, irq);
    end
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) begin
        bus(0, 1, ra(c, r), 0);
        n_tests++;
        if (readdata !== 32'd0 || readdata !== m_rd) begin
          n_fail++; $display("FAIL reset_reg ch%0d r%0d: got %0h required 0", c, r, readdata);
        end
      end
  endtask

  task automatic test_start_stop();
    bus(1, 0, ra(0, 0), 1);
    repeat (10) bus(0, 0, 0, 0);
    bus(1, 0, ra(0, 0), 2);
    bus(0, 1, ra(0, 1), 0);
    n_tests++;
    if (readdata !== 32'd10 || readdata !== m_rd) begin
      n_fail++; $display("FAIL start_stop_count: got %0d required 10 (model %0d)", readdata, m_rd);
    end
    for (int c = 1; c < NCH; c++) begin
      bus(0, 1, ra(c, 1), 0);
      n_tests++;
      if (readdata !== 32'd0) begin
        n_fail++; $display("FAIL idle_channel_count ch%0d: got %0d required 0", c, readdata);
      end
    end
  endtask

  task automatic test_wrap();
    bus(1, 0, ra(0, 0), 3);
    bus(1, 0, ra(0, 3), 0);
    bus(1, 0, ra(0, 2), 5);
    bus(1, 0, ra(0, 1), 32'hFE);
    bus(1, 0, ra(0, 0), 4);
    bus(1, 0, ra(0, 0), 1);
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] exp = (254 + k - 1) & MASK;
      bus(0, 1, ra(0, 1), 0);
      n_tests++;
      if (readdata !== exp || readdata !== m_rd || irq !== 1'b0) begin
        n_fail++; $display("FAIL wrap_count k=%0d: got %0h irq=%b required %0h irq=0", k, readdata, irq, exp);
      end
    end
    bus(0, 1, ra(0, 0), 0);
    n_tests++;
    if (readdata !== 32'h3 || readdata !== m_rd) begin
      n_fail++; $display("FAIL wrap_status: got %0h required 3", readdata);
    end
    bus(1, 0, ra(0, 0), 2);
  endtask

  task automatic test_auto_reload();
    bus(1, 0, ra(2, 3), 5);
    bus(1, 0, ra(2, 2), 3);
    bus(1, 0, ra(2, 0), 1);
    for (int k = 1; k <= 12; k++) begin
      bus(0, 1, ra(2, 1), 0);
      n_tests++;
      if (readdata !== 32'((k - 1) % 4) || irq !== (k >= 5) || readdata !== m_rd || irq !== m_irq) begin
        n_fail++; $display("FAIL reload_seq k=%0d: count=%0d irq=%b required %0d irq=%b", k, readdata, irq, (k - 1) % 4, k >= 5);
      end
    end
    bus(1, 0, ra(2, 0), 4);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_clear_edge: got %b required 1", irq); end
    bus(0, 0, 0, 0);
    n_tests++;
    if (irq !== 1'b0 || irq !== m_irq) begin n_fail++; $display("FAIL irq_drop: got %b required 0", irq); end
    bus(0, 0, 0, 0);
    bus(1, 0, ra(2, 0), 4);
    bus(0, 1, ra(2, 0), 0);
    n_tests++;
    if (readdata !== 32'h17 || irq !== 1'b1 || readdata !== m_rd) begin
      n_fail++; $display("FAIL clear_vs_match: status=%0h irq=%b required 17 irq=1", readdata, irq);
    end
  endtask

  task automatic test_async_reset();
    n_tests++;
    if (readdata !== 32'h17 || irq !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: readdata=%0h irq=%b required 17/1", readdata, irq);
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: readdata=%0h irq=%b required 0/0", readdata, irq);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      bus(0, 1, ra(c, 1), 0);
      n_tests++;
      if (readdata !== 32'd0) begin n_fail++; $display("FAIL post_reset_count ch%0d: got %0d required 0", c, readdata); end
    end
    bus(0, 1, ra(2, 0), 0);
    n_tests++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL post_reset_status: got %0h required 0", readdata); end
  endtask

  task automatic test_one_shot();
    bus(1, 0, ra(3, 3), 2);
    bus(1, 0, ra(3, 2), 4);
    bus(1, 0, ra(3, 0), 1);
    repeat (8) bus(0, 0, 0, 0);
    bus(0, 1, ra(3, 1), 0);
    n_tests++;
    if (readdata !== 32'd4 || readdata !== m_rd) begin n_fail++; $display("FAIL oneshot_count: got %0d required 4", readdata); end
    bus(0, 1, ra(3, 0), 0);
    n_tests++;
    if (readdata !== 32'hA || readdata !== m_rd) begin n_fail++; $display("FAIL oneshot_status: got %0h required a", readdata); end
    bus(1, 0, ra(3, 1), 0);
    bus(0, 1, ra(3, 1), 0);
    n_tests++;
    if (readdata !== 32'd0 || readdata !== m_rd) begin n_fail++; $display("FAIL oneshot_load: got %0d required 0", readdata); end
  endtask

  task automatic test_simultaneous();
    bus(1, 0, ra(1, 3), 0);
    bus(1, 0, ra(1, 2), 3);
    bus(1, 0, ra(1, 0), 1);
    repeat (3) bus(0, 0, 0, 0);
    bus(1, 0, ra(1, 0), 2);
    bus(0, 1, ra(1, 1), 0);
    n_tests++;
    if (readdata !== 32'd3 || readdata !== m_rd) begin n_fail++; $display("FAIL stop_on_match_count: got %0d required 3", readdata); end
    bus(0, 1, ra(1, 0), 0);
    n_tests++;
    if (readdata !== 32'h2 || readdata !== m_rd) begin n_fail++; $display("FAIL stop_on_match_status: got %0h required 2", readdata); end
    bus(1, 0, ra(1, 0), 4);
    bus(1, 0, ra(1, 0), 1);
    bus(1, 0, ra(1, 0), 3);
    bus(0, 1, ra(1, 0), 0);
    n_tests++;
    if (readdata !== 32'h1 || readdata !== m_rd) begin n_fail++; $display("FAIL clear_count_no_match: got %0h required 1", readdata); end
    bus(0, 0, 0, 0);
    bus(0, 0, 0, 0);
    bus(1, 0, ra(1, 2), 9);
    bus(0, 1, ra(1, 0), 0);
    n_tests++;
    if (readdata !== 32'h3 || readdata !== m_rd) begin n_fail++; $display("FAIL compare_write_old_value: got %0h required 3", readdata); end
    bus(0, 1, ra(1, 2), 0);
    n_tests++;
    if (readdata !== 32'd9) begin n_fail++; $display("FAIL compare_written: got %0d required 9", readdata); end
    bus(1, 0, ra(1, 0), 2);
  endtask

  task automatic test_bad_addr();
    bus(1, 0, ra(0, 2), 32'h21);
    bus(1, 0, {3'b001, 3'd0, 2'd2}, 32'h77);
    bus(1, 0, {3'b100, 3'd0, 2'd0}, 32'h1);
    bus(0, 1, ra(0, 2), 0);
    n_tests++;
    if (readdata !== 32'h21 || readdata !== m_rd) begin n_fail++; $display("FAIL bad_addr_write: got %0h required 21", readdata); end
    bus(0, 1, {3'b010, 3'd0, 2'd2}, 0);
    n_tests++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL bad_addr_read: got %0h required 0", readdata); end
    bus(0, 1, ra(0, 2), 0);
    bus(0, 1, ra(5, 2), 0);
    n_tests++;
    if (readdata !== 32'd0) begin n_fail++; $display("FAIL bad_channel_read: got %0h required 0", readdata); end
    bus(0, 1, ra(0, 0), 0);
    n_tests++;
    if (readdata !== 32'd0 || readdata !== m_rd) begin n_fail++; $display("FAIL bad_addr_cmd: got %0h required 0", readdata); end
  endtask

  task automatic test_prescale();
    logic [31:0] exp_cfg;
    bus(1, 0, ra(0, 3), 32'hABCD_0000);
    bus(0, 1, ra(0, 3), 0);
`ifdef TIMER_PRESCALE_EN
    exp_cfg = 32'hABCD_0000;
`else
    exp_cfg = 32'h0;
`endif
    n_tests++;
    if (readdata !== exp_cfg || readdata !== m_rd) begin n_fail++; $display("FAIL config_high: got %0h required %0h", readdata, exp_cfg); end
`ifdef TIMER_PRESCALE_EN
    bus(1, 0, ra(0, 3), 32'h0002_0000);
    bus(1, 0, ra(0, 2), 1);
    bus(1, 0, ra(0, 0), 3);
    bus(1, 0, ra(0, 0), 4);
    bus(1, 0, ra(0, 0), 1);
    for (int k = 1; k <= 8; k++) begin
      bus(0, 1, ra(0, 0), 0);
      n_tests++;
      if (readdata[1] !== (k >= 7) || readdata !== m_rd) begin
        n_fail++; $display("FAIL prescale_match k=%0d: flag=%b required %b", k, readdata[1], k >= 7);
      end
    end
    bus(1, 0, ra(0, 0), 2);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      bit w = ($urandom_range(0, 2) == 0);
      bit r = $urandom_range(0, 1);
      a[7:5] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      a[4:2] = 3'($urandom_range(0, 4));
      a[1:0] = 2'($urandom_range(0, 3));
      case (a[1:0])
        2'd0:    d = $urandom_range(0, 7);
        2'd3:    d = {16'($urandom_range(0, 3)), 13'd0, 3'($urandom_range(0, 7))};
        default: d = $urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 32'hF0 : 32'h0);
      endcase
      bus(w, r, a, d);
      n_tests++;
      if (readdata !== m_rd || irq !== m_irq) begin
        n_fail++; $display("FAIL random n=%0d: readdata=%0h irq=%b required %0h irq=%b", n, readdata, irq, m_rd, m_irq);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    test_reset();
    test_start_stop();
    test_wrap();
    test_auto_reload();
    test_async_reset();
    test_one_shot();
    test_simultaneous();
    test_bad_addr();
    test_prescale();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
